// File: rtl/lab2_window_monitor.sv
// Per-window statistics for the Lab 2 stimulus stream: counts b toggles and
// measures the advance of c across each high interval of a, then pulses done.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a to rise
// OPEN   | window open, counting b toggles
// REPORT | results valid, done high for this single cycle
module lab2_window_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic [7:0]       c,
    output logic [1:0]       state,
    output logic             done,
    output logic [CNT_W-1:0] b_cnt,
    output logic [7:0]       c_delta,
    output logic [WIN_W-1:0] win_cnt,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           st;
    logic             a_s, a_d, b_s, b_d;
    logic [7:0]       c_s;
    logic [7:0]       c_start;
    logic [CNT_W-1:0] run_cnt;

    logic             a_rise, a_fall, b_tog;
    logic             cnt_at_max;
    logic [CNT_W-1:0] close_cnt;

    assign a_rise     = a_s & ~a_d;
    assign a_fall     = ~a_s & a_d;
    assign b_tog      = b_s ^ b_d;
    assign cnt_at_max = (run_cnt == CNT_MAX);

    // Count as it stands at close, including a toggle landing on the a_fall cycle.
    assign close_cnt  = (b_tog && !cnt_at_max) ? run_cnt + CNT_W'(1) : run_cnt;

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s <= 1'b0;
            a_d <= 1'b0;
            b_s <= 1'b0;
            b_d <= 1'b0;
            c_s <= 8'd0;
        end else begin
            a_s <= a;
            a_d <= a_s;
            b_s <= b;
            b_d <= b_s;
            c_s <= c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            run_cnt <= '0;
            c_start <= 8'd0;
            done    <= 1'b0;
            b_cnt   <= '0;
            c_delta <= 8'd0;
            win_cnt <= '0;
            sat     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (a_rise) begin
                        c_start <= c_s;
                        run_cnt <= '0;
                        st      <= OPEN;
                    end
                end
                OPEN: begin
                    if (b_tog && cnt_at_max) begin
                        sat <= 1'b1;
                    end
                    if (a_fall) begin
                        b_cnt   <= close_cnt;
                        c_delta <= c_s - c_start;
                        win_cnt <= win_cnt + WIN_W'(1);
                        done    <= 1'b1;
                        st      <= REPORT;
                    end else begin
                        run_cnt <= close_cnt;
                    end
                end
                REPORT: begin
                    // A one-sample gap in a reopens straight from here.
                    if (a_rise) begin
                        c_start <= c_s;
                        run_cnt <= '0;
                        st      <= OPEN;
                    end else begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_window_monitor.sv
// Scoreboard bench: a default-width and a narrow (CNT_W=2, WIN_W=2) monitor
// share one stimulus stream; expected window results are queued per instance.
module tb_lab2_window_monitor;

    typedef struct {
        logic [7:0] b_cnt;
        logic [7:0] c_delta;
        logic [7:0] win_cnt;
        logic       sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [7:0] c = 8'd0;

    logic [1:0] state0, state1;
    logic       done0, done1;
    logic [7:0] b_cnt0;
    logic [1:0] b_cnt1;
    logic [7:0] c_delta0, c_delta1;
    logic [7:0] win_cnt0;
    logic [1:0] win_cnt1;
    logic       sat0, sat1;

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   wins = 0;
    bit   sat_m0 = 1'b0;
    bit   sat_m1 = 1'b0;

    always #10 clk = ~clk;

    lab2_window_monitor dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .state(state0), .done(done0), .b_cnt(b_cnt0), .c_delta(c_delta0),
        .win_cnt(win_cnt0), .sat(sat0)
    );

    lab2_window_monitor #(.CNT_W(2), .WIN_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .state(state1), .done(done1), .b_cnt(b_cnt1), .c_delta(c_delta1),
        .win_cnt(win_cnt1), .sat(sat1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done0) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0 b_cnt", {24'd0, b_cnt0}, {24'd0, e.b_cnt});
                chk("dut0 c_delta", {24'd0, c_delta0}, {24'd0, e.c_delta});
                chk("dut0 win_cnt", {24'd0, win_cnt0}, {24'd0, e.win_cnt});
                chk("dut0 sat", {31'd0, sat0}, {31'd0, e.sat});
                chk("dut0 state REPORT", {30'd0, state0}, 32'd2);
            end
        end
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1 b_cnt", {30'd0, b_cnt1}, {24'd0, e.b_cnt});
                chk("dut1 c_delta", {24'd0, c_delta1}, {24'd0, e.c_delta});
                chk("dut1 win_cnt", {30'd0, win_cnt1}, {24'd0, e.win_cnt});
                chk("dut1 sat", {31'd0, sat1}, {31'd0, e.sat});
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, " state0"}, {30'd0, state0}, 32'd0);
        chk({tag, " done0"}, {31'd0, done0}, 32'd0);
        chk({tag, " b_cnt0"}, {24'd0, b_cnt0}, 32'd0);
        chk({tag, " c_delta0"}, {24'd0, c_delta0}, 32'd0);
        chk({tag, " win_cnt0"}, {24'd0, win_cnt0}, 32'd0);
        chk({tag, " sat0"}, {31'd0, sat0}, 32'd0);
        chk({tag, " state1"}, {30'd0, state1}, 32'd0);
        chk({tag, " win_cnt1"}, {30'd0, win_cnt1}, 32'd0);
        chk({tag, " sat1"}, {31'd0, sat1}, 32'd0);
    endtask

    task automatic do_reset(input logic a_val, input logic [7:0] c_val);
        @(negedge clk);
        rst_n = 1'b0;
        a = a_val;
        c = c_val;
        wins = 0;
        sat_m0 = 1'b0;
        sat_m1 = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ntog counts toggles inside the window, including one on the closing sample
    // when tog_fall is set; tog_rise adds an uncounted toggle on the opening sample.
    task automatic window(input int ntog, input logic [7:0] c0, input logic [7:0] c1,
                          input bit tog_fall, input bit tog_rise);
        exp_t e0, e1;
        int body;
        body = tog_fall ? ntog - 1 : ntog;
        @(negedge clk);
        a = 1'b1;
        c = c0;
        if (tog_rise) b = ~b;
        for (int i = 0; i < body; i++) begin
            @(negedge clk);
            b = ~b;
        end
        @(negedge clk);
        a = 1'b0;
        c = c1;
        if (tog_fall) b = ~b;
        wins++;
        if (ntog > 255) sat_m0 = 1'b1;
        if (ntog > 3) sat_m1 = 1'b1;
        e0.b_cnt   = (ntog > 255) ? 8'd255 : 8'(ntog);
        e0.c_delta = c1 - c0;
        e0.win_cnt = 8'(wins % 256);
        e0.sat     = sat_m0;
        e1.b_cnt   = (ntog > 3) ? 8'd3 : 8'(ntog);
        e1.c_delta = c1 - c0;
        e1.win_cnt = 8'(wins % 4);
        e1.sat     = sat_m1;
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    initial begin
        // Reset and hold with a low.
        do_reset(1'b0, 8'd0);
        idle(2);
        chk("idle state0", {30'd0, state0}, 32'd0);

        // Single window: b 0->1->0, c 1 -> 2.
        window(2, 8'd1, 8'd2, 1'b0, 1'b0);
        idle(4);

        // Stimulus-generator style: a high out of reset, three windows of 2 toggles.
        do_reset(1'b1, 8'd0);
        window(2, 8'd0, 8'd1, 1'b0, 1'b0);
        idle(1);
        window(2, 8'd1, 8'd2, 1'b0, 1'b0);
        idle(1);
        window(2, 8'd2, 8'd3, 1'b0, 1'b0);
        idle(4);
        chk("gen win_cnt0", {24'd0, win_cnt0}, 32'd3);
        chk("gen win_cnt1", {30'd0, win_cnt1}, 32'd3);

        // c wrap, back-to-back windows, fall-coincident and rise-coincident toggles.
        do_reset(1'b0, 8'd0);
        window(1, 8'hFE, 8'h03, 1'b0, 1'b0);
        idle(2);
        window(3, 8'h10, 8'h30, 1'b1, 1'b0);
        window(1, 8'h30, 8'h31, 1'b1, 1'b1);
        window(0, 8'h80, 8'h7F, 1'b0, 1'b1);
        idle(1);
        window(2, 8'h05, 8'h05, 1'b0, 1'b0);
        idle(4);
        chk("wrap win_cnt0", {24'd0, win_cnt0}, 32'd5);
        chk("wrap win_cnt1", {30'd0, win_cnt1}, 32'd1);

        // Saturation on the narrow counter, then sat stays set.
        do_reset(1'b0, 8'd0);
        window(5, 8'd0, 8'd9, 1'b0, 1'b0);
        idle(3);
        window(1, 8'd9, 8'd10, 1'b0, 1'b0);
        idle(4);
        chk("sat1 sticky", {31'd0, sat1}, 32'd1);
        window(4, 8'd10, 8'd11, 1'b1, 1'b0);
        idle(4);

        // Reset mid-window: immediate IDLE, no done, counters cleared.
        do_reset(1'b0, 8'd0);
        @(negedge clk);
        a = 1'b1;
        c = 8'd4;
        repeat (3) begin
            @(negedge clk);
            b = ~b;
        end
        @(posedge clk);
        #3;
        chk("mid state0 open", {30'd0, state0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid async state0", {30'd0, state0}, 32'd0);
        chk("mid async state1", {30'd0, state1}, 32'd0);
        @(negedge clk);
        a = 1'b0;
        c = 8'd7;
        idle(1);
        rst_n = 1'b1;
        idle(5);
        check_outputs_zero("after mid reset");

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("q0 drained", q0.size(), 32'd0);
        chk("q1 drained", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab2_window_monitor.md
# lab2_window_monitor

Consumes the `a`, `b` and 8-bit `c` stimulus stream produced by the Lab 2 waveform generator and reduces it to per-window statistics. A window is one high interval of `a`. During each window the block counts toggles of `b` and measures how far `c` advanced, then reports both with a one-cycle `done` pulse. It sits directly downstream of the stimulus stage and feeds the lab's result checker and waveform inspection.

## Interface
- `CNT_W`, default 8: width of the `b` toggle counter and of `b_cnt`.
- `WIN_W`, default 8: width of the completed-window counter `win_cnt`.

- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `a`  in  1: window enable; a window is open while `a` is high.
- `b`  in  1: event line; every transition of `b` (rise or fall) counts.
- `c`  in  8: running value; its advance over the window is measured.
- `state`  out  2: FSM state, IDLE=0, OPEN=1, REPORT=2.
- `done`  out  1: one-cycle pulse when a window's results are valid.
- `b_cnt`  out  CNT_W: `b` toggles counted in the last closed window.
- `c_delta`  out  8: `c` at close minus `c` at open, modulo 256.
- `win_cnt`  out  WIN_W: number of completed windows, wraps.
- `sat`  out  1: sticky flag, set if any window's toggle count saturated.

## Operation
- Input stage: `a`, `b` and `c` are registered into `a_s`, `b_s`, `c_s`. Delay regs `a_d` and `b_d` hold the previous `a_s` and `b_s`.
- Edge terms are combinational from the registers:
  - `a_rise = a_s & ~a_d`
  - `a_fall = ~a_s & a_d`
  - `b_tog = b_s ^ b_d`
- Reset clears every register and output to 0, including `a_s`, `a_d`, `b_s`, `b_d`, `c_s`, the internal counter and `c_start`. State resets to IDLE.
- IDLE:
  - On `a_rise`: load `c_start = c_s`, clear the running count, go to OPEN.
  - `b_tog` is ignored.
- OPEN:
  - Each `b_tog` cycle increments the running count. The count saturates at 2^CNT_W−1; an increment attempted at the maximum sets `sat`.
  - On `a_fall`:
    - `b_cnt` = running count plus 1 if `b_tog` is active in the same cycle (saturating).
    - `c_delta = c_s − c_start` (8-bit wrap).
    - `win_cnt` increments (wraps).
    - Go to REPORT.
- REPORT:
  - `done` = 1 for exactly this cycle.
  - On `a_rise`, do the IDLE→OPEN actions and go to OPEN. Otherwise go to IDLE.
- `b_cnt`, `c_delta` and `win_cnt` hold their values until the next window closes.
- `sat` clears only on reset.
- `a` high coming out of reset gives `a_rise` on the first sample, so a window opens.

## Timing
- Input sampled at edge N appears in `a_s` after N. The FSM and outputs react at edge N+1, so latency is 2 clocks from the input edge to the state change.
- `done`, `b_cnt`, `c_delta` and `win_cnt` update at the same edge that enters REPORT. Outputs are valid while `done` = 1.
- The minimum `a` low time is 1 sample: a REPORT→OPEN transition is taken without passing through IDLE.
- `b_tog` in the cycle of `a_rise` is not counted, because the count clears.
- `b_tog` in the cycle of `a_fall` is counted.
- Reset assertion mid-window forces IDLE immediately, asynchronously. The partial window is discarded, and `done` never pulses for it.

## Test plan
- Reset then hold: `rst_n` = 0 for 3 cycles with `a` = 0 → all outputs 0 and `state` = 0.
- Single window: `a` rises, `c` = 1. `b` toggles 0→1→0 on separate cycles. `c` → 2 and `a` falls → one `done` pulse with `b_cnt` = 2, `c_delta` = 1, `win_cnt` = 1.
- Stimulus-generator sequence (20 ns clock, `a` starting high, pattern of 2, 2, 2 `b` toggles): 3 `done` pulses, each `c_delta` = 1, then `win_cnt` = 3.
- Wrap: `c_start` = 0xFE, close at `c` = 0x03 → `c_delta` = 0x05. With `WIN_W` = 2, 5 windows → `win_cnt` = 1.
- Saturation: `CNT_W` = 2, 5 `b` toggles in one window → `b_cnt` = 3 and `sat` = 1. `sat` remains 1 after the next window with 1 toggle (`b_cnt` = 1).
- Edge cases:
  - `a` low for 1 sample → REPORT→OPEN directly, `done` pulses once.
  - `b_tog` coincident with `a_fall` is counted.
  - `rst_n` low mid-OPEN → no `done`, `win_cnt` = 0.
